// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared geometry and state definitions for the 320x240 4-bit grayscale frame
// buffer. The capture-side writer (frame_packer), the gradient engine and the
// display reader all import this package, so the packing and addressing
// constants below are the single source of truth for the buffer layout.
//
// Contents:
//   H_PIX, V_PIX        frame size in pixels
//   PIX_W               stored pixel width (bits)
//   PIX_PER_WORD        pixels packed per memory word
//   WORDS_PER_ROW       memory words per raster row
//   FRAME_WORDS         memory words per frame
//   ADDR_W              frame buffer word-address width
//   WORD_W, X_W, Y_W    derived word width and raster counter widths
//   state_t             capture FSM states
//   word_addr()         80*y + x/4 address for the word holding pixel (x,y)
// -----------------------------------------------------------------------------
package frame_pkg;

  localparam int H_PIX         = 320;
  localparam int V_PIX         = 240;
  localparam int PIX_W         = 4;
  localparam int PIX_PER_WORD  = 4;
  localparam int WORDS_PER_ROW = 80;
  localparam int FRAME_WORDS   = 19200;
  localparam int ADDR_W        = 15;

  localparam int WORD_W = PIX_W * PIX_PER_WORD;
  localparam int X_W    = 9;
  localparam int Y_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // 80*y is formed as 64*y + 16*y so no multiplier is needed; x/4 is the word
  // column because four pixels share one word.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col;
    row_base = ADDR_W'({y, 6'b0}) + ADDR_W'({y, 4'b0});
    col      = ADDR_W'(x[X_W-1:2]);
    return row_base + col;
  endfunction

endpackage

// File: rtl/frame_packer_nibble_packer.sv
// -----------------------------------------------------------------------------
// nibble_packer
// Four-stage nibble shift register. Each accepted nibble shifts in at the
// bottom, so the first nibble of a group ends up in the top bits of the word.
// Three nibbles are held in registers; the fourth is the incoming nibble, so
// the complete word and its ready strobe are available combinationally in the
// same cycle the fourth nibble is presented.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset (clears the nibble index)
//   shift       in   nibble present and accepted this cycle
//   clear       in   restart grouping; with shift=1 the incoming nibble
//                    becomes nibble 0 of a new word, with shift=0 the index
//                    returns to 0
//   nib         in   PIX_W-bit nibble
//   word_ready  out  the incoming nibble completes a word this cycle
//   word        out  packed word {n0, n1, n2, n3}, valid with word_ready
// -----------------------------------------------------------------------------
module nibble_packer
  import frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift,
  input  logic              clear,
  input  logic [PIX_W-1:0]  nib,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);

  logic [1:0]                            idx;
  logic [(PIX_PER_WORD-1)*PIX_W-1:0]     sr_p0;

  // Index wraps 3->0 naturally; a clear with a shift makes the incoming
  // nibble the first of a fresh word, discarding whatever was held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else if (clear) begin
      idx <= shift ? 2'd1 : 2'd0;
    end else if (shift) begin
      idx <= idx + 2'd1;
    end
  end

  // Data path carries no reset: stale contents are always shifted out before
  // a word is declared ready.
  always_ff @(posedge clk) begin
    if (shift) begin
      sr_p0 <= {sr_p0[(PIX_PER_WORD-2)*PIX_W-1:0], nib};
    end
  end

  always_comb begin
    word_ready = shift && !clear && (idx == 2'd3);
    word       = {sr_p0, nib};
  end

endmodule

// File: rtl/frame_packer.sv
// -----------------------------------------------------------------------------
// frame_packer
// Capture-side writer for the 320x240 4-bit grayscale frame buffer. Accepts a
// raster-ordered pixel stream, keeps the top 4 bits of each pixel, packs four
// consecutive pixels per 16-bit word (leftmost pixel in din[15:12]) and writes
// the words to addresses 0..19199, row-major, 80 words per row.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   pix_valid   in   pixel present this cycle
//   pix_sof     in   start of frame (qualified by pix_valid)
//   pix_data    in   IN_W-bit pixel, bits [IN_W-1:IN_W-4] kept
//   capture_en  in   arm capture of the next frame (sampled in IDLE only)
//   wea         out  frame buffer write strobe, one cycle per word
//   addr_write  out  word address 80*row + col_word (held while wea=0)
//   din         out  packed word (held while wea=0)
//   busy        out  high while capturing
//   frame_done  out  pulse with the write to the last address (19199)
//   frame_err   out  pulse one cycle after a sof aborts a frame in progress
// -----------------------------------------------------------------------------
module frame_packer
  import frame_pkg::*;
#(
  parameter int IN_W = 8
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [IN_W-1:0]   pix_data,
  input  logic              capture_en,
  output logic              wea,
  output logic [ADDR_W-1:0] addr_write,
  output logic [WORD_W-1:0] din,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIX - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIX - 1);

  state_t            state;
  state_t            state_nx;

  // Raster position of the next pixel to be accepted.
  logic [X_W-1:0]    x_cnt;
  logic [Y_W-1:0]    y_cnt;

  logic              at_origin;
  logic              start;
  logic              restart;
  logic              accept;
  logic              last_pix;
  logic              pk_clear;

  logic [PIX_W-1:0]  nib_p0;
  logic              word_vld_p0;
  logic [WORD_W-1:0] word_p0;

  // Only the top PIX_W bits of the pixel are stored.
  logic              unused_low_bits;

  assign nib_p0          = pix_data[IN_W-1 -: PIX_W];
  assign unused_low_bits = ^pix_data[IN_W-PIX_W-1:0];

  // ---------------------------------------------------------------------------
  // Stage 0: pixel qualification and grouping
  // ---------------------------------------------------------------------------
  // A sof in CAPTURE is a restart unless it lands on the position the frame
  // expects as its first pixel; the restarting pixel itself becomes (0,0).
  always_comb begin
    at_origin = (x_cnt == '0) && (y_cnt == '0);
    start     = (state == ARMED) && pix_valid && pix_sof;
    restart   = (state == CAPTURE) && pix_valid && pix_sof && !at_origin;
    accept    = start || ((state == CAPTURE) && pix_valid);
    last_pix  = (state == CAPTURE) && pix_valid && !restart &&
                (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    // Outside CAPTURE the packer is held empty; a restart drops the partial
    // word and seeds a new one with the sof pixel.
    pk_clear  = (state != CAPTURE) || restart;
  end

  nibble_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift      (accept),
    .clear      (pk_clear),
    .nib        (nib_p0),
    .word_ready (word_vld_p0),
    .word       (word_p0)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (capture_en) state_nx = ARMED;
      ARMED:   if (start)      state_nx = CAPTURE;
      CAPTURE: if (last_pix)   state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = (state == CAPTURE);
  end

  // Raster counters. The first pixel of a frame (start or restart) has been
  // consumed as (0,0), so the next expected position is (1,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (start || restart) begin
      x_cnt <= X_W'(1);
      y_cnt <= '0;
    end else if ((state == CAPTURE) && pix_valid) begin
      if (last_pix) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + Y_W'(1);
      end else begin
        x_cnt <= x_cnt + X_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: registered write port
  // ---------------------------------------------------------------------------
  // The counters still point at the pixel completing the word, so its x/4
  // gives the word column. Address and data only move on a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wea        <= 1'b0;
      addr_write <= '0;
      din        <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wea        <= word_vld_p0;
      frame_done <= word_vld_p0 && last_pix;
      frame_err  <= restart;
      if (word_vld_p0) begin
        addr_write <= word_addr(x_cnt, y_cnt);
        din        <= word_p0;
      end
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
module tb_frame_packer;

  logic        clk;
  logic        rst_n;
  logic        pix_valid;
  logic        pix_sof;
  logic [7:0]  pix_data;
  logic        capture_en;
  logic        wea;
  logic [14:0] addr_write;
  logic [15:0] din;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  frame_packer #(.IN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_data   (pix_data),
    .capture_en (capture_en),
    .wea        (wea),
    .addr_write (addr_write),
    .din        (din),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] din;
    logic        done;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          err_cnt = 0;
  int          err_cyc = -1;
  int          done_cnt = 0;
  int          done_addr = -1;
  int          sof_cyc = 0;
  bit          busy_seen = 1'b0;
  logic [15:0] din_at0 = 16'h0;
  logic [15:0] din_at79 = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected packed word: source pixels carry x%16 in their upper nibble, so
  // the word at column w holds (4w)%16 .. (4w+3)%16.
  function automatic logic [15:0] exp_din(input int w);
    logic [3:0] a;
    a = 4'((4 * w) % 16);
    return {a, a + 4'd1, a + 4'd2, a + 4'd3};
  endfunction

  task automatic push_range(input int a0, input int a1);
    wr_t e;
    for (int a = a0; a <= a1; a++) begin
      e.addr = 15'(a);
      e.din  = exp_din(a % 80);
      e.done = (a == 19199);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares every write against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (frame_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (wea === 1'b1) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual addr=%0d din=%h required none", addr_write, din);
      end else begin
        e = exp_q.pop_front();
        if (addr_write !== e.addr || din !== e.din || frame_done !== e.done) begin
          bad++;
          $display("FAIL write actual addr=%0d din=%h done=%b required addr=%0d din=%h done=%b",
                   addr_write, din, frame_done, e.addr, e.din, e.done);
        end
      end
      if (addr_write == 15'd0)  din_at0  = din;
      if (addr_write == 15'd79) din_at79 = din;
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_addr = int'(addr_write);
      end
    end else if (frame_done === 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_without_write actual frame_done=1 required 0");
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
    end
  endtask

  task automatic px(input int x, input int y, input bit sof);
    @(posedge clk); #1;
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = {4'(x), 4'(x >> 4) ^ 4'hA};
  endtask

  task automatic arm();
    @(posedge clk); #1;
    capture_en = 1'b1;
    @(posedge clk); #1;
    capture_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_wea"},   32'(wea),        32'd0);
    chk({tag, "_addr"},  32'(addr_write), 32'd0);
    chk({tag, "_din"},   32'(din),        32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(frame_done), 32'd0);
    chk({tag, "_err"},   32'(frame_err),  32'd0);
  endtask

  initial begin
    bit stop;
    rst_n      = 1'b0;
    pix_valid  = 1'b0;
    pix_sof    = 1'b0;
    pix_data   = 8'h00;
    capture_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // capture_en low: a full-rate stream with sof produces nothing
    busy_seen = 1'b0;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 320; x++)
        px(x, y, (x == 0 && y == 0));
    idle(4);
    chk("noarm_writes", 32'(wr_cnt), 32'd0);
    chk("noarm_busy_seen", 32'(busy_seen), 32'd0);

    // Armed with a stream joining mid-frame: dropped until the next sof
    arm();
    for (int x = 100; x < 140; x++) px(x, 3, 1'b0);
    idle(2);
    @(negedge clk);
    chk("armed_busy", 32'(busy), 32'd0);
    chk("armed_writes", 32'(wr_cnt), 32'd0);

    // Full frame at full rate
    push_range(0, 19199);
    for (int y = 0; y < 240; y++) begin
      for (int x = 0; x < 320; x++) begin
        px(x, y, (x == 0 && y == 0));
        if (y == 0 && x == 3) begin
          @(negedge clk);
          chk("lat_before", 32'(wea), 32'd0);
        end else if (y == 0 && x == 4) begin
          @(negedge clk);
          chk("lat_wea", 32'(wea), 32'd1);
          chk("lat_addr", 32'(addr_write), 32'd0);
        end else if (y == 0 && x == 5) begin
          @(negedge clk);
          chk("lat_after", 32'(wea), 32'd0);
        end
      end
    end
    idle(4);
    @(negedge clk);
    chk("full_pending", 32'(exp_q.size()), 32'd0);
    chk("full_writes", 32'(wr_cnt), 32'd19200);
    chk("full_done_cnt", 32'(done_cnt), 32'd1);
    chk("full_done_addr", 32'(done_addr), 32'd19199);
    chk("full_din_addr0", 32'(din_at0), 32'h0123);
    chk("full_din_addr79", 32'(din_at79), 32'hCDEF);
    chk("full_busy_after", 32'(busy), 32'd0);
    chk("full_hold_addr", 32'(addr_write), 32'd19199);
    chk("full_hold_din", 32'(din), 32'hCDEF);
    chk("full_err_cnt", 32'(err_cnt), 32'd0);

    // Gapped stream, then a sof at (6,10) aborts the frame
    arm();
    push_range(0, 800);
    stop = 1'b0;
    for (int y = 0; y <= 10 && !stop; y++) begin
      for (int x = 0; x < 320 && !stop; x++) begin
        if (y == 10 && x == 6) begin
          stop = 1'b1;
        end else begin
          px(x, y, (x == 0 && y == 0));
          if (y < 2 && (x % 2) == 0) idle(2);
        end
      end
    end
    // New frame begins with the offending sof pixel as (0,0)
    push_range(0, 79);
    px(0, 0, 1'b1);
    sof_cyc = cyc;
    for (int x = 1; x < 320; x++) px(x, 0, 1'b0);
    px(0, 1, 1'b0);
    px(1, 1, 1'b0);
    // Reset two pixels into a word: partial word is lost
    @(posedge clk); #1;
    pix_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    @(negedge clk);
    chk("restart_pending", 32'(exp_q.size()), 32'd0);
    chk("restart_err_cnt", 32'(err_cnt), 32'd1);
    chk("restart_err_cyc", 32'(err_cyc), 32'(sof_cyc + 1));
    chk("restart_writes", 32'(wr_cnt), 32'd19200 + 32'd801 + 32'd80);
    check_outputs_zero("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
